conv2_sched: RTL
================

# conv2_sched

Sequencing controller for the second convolution layer (5x5 kernel, 6 input channels, 16 output channels) on a 12x12 input feature map. It paces the incoming pixel stream and detects when a full 5x5 window is resident in the line buffers and window registers. For each window it stalls the input and issues 96 MAC steps: one weight-ROM address and one input-channel select per cycle, plus accumulator clear/last strobes. It tags each finished accumulation with its output channel and window coordinates. It sits between the conv1/pool1 output stream and the conv2 line-buffer/MAC datapath, replacing ad-hoc counter logic inside the datapath.

## Interface
Parameters:
- IMG_W, 12, input feature-map width (pixels per row)
- IMG_H, 12, input feature-map height (rows per frame)
- K, 5, kernel size
- IN_CH, 6, input channels per pixel
- OUT_CH, 16, output channels
- MAC_LAT, 3, cycles from an issue cycle to the accumulator result for that issue being registered (multiply + sum + accumulate)

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  upstream pixel (all IN_CH channels) available
- s_ready  out  1  scheduler accepts a pixel; a pixel is taken on a cycle with s_valid && s_ready
- pix_we  out  1  equals s_valid && s_ready; line-buffer/window shift enable
- mac_en  out  1  datapath MAC issue this cycle
- in_ch_sel  out  3  input channel selected into the MAC array (0..IN_CH-1)
- w_addr  out  7  weight ROM address, out_ch*IN_CH + in_ch (0..95)
- acc_clr  out  1  issue is the first of an accumulation (in_ch==0); accumulator loads instead of adds
- acc_last  out  1  issue is the last of an accumulation (in_ch==IN_CH-1)
- out_valid  out  1  accumulator output is final this cycle
- out_ch  out  4  output channel of the out_valid result
- out_row, out_col  out  3 each  window position (0..IMG_H-K, 0..IMG_W-K) of the out_valid result
- frame_done  out  1  one-cycle pulse coincident with the last out_valid of a frame
- busy  out  1  high in COMPUTE or DRAIN

## Operation
- States: FILL, COMPUTE, DRAIN.
- Reset: state FILL, all counters 0, delay line flushed. s_ready=1, and every other output is 0.
- Reset asserted in any state, including mid-COMPUTE, aborts the frame. The next cycle behaves as a fresh frame. Any pending out_valid is discarded.
- **FILL**
  - s_ready=1, combinational from state.
  - On each accepted pixel, (col,row) advances: col wraps IMG_W-1→0 and increments row.
  - If the accepted pixel has row>=K-1 and col>=K-1, the state goes to COMPUTE on the next cycle. The window position is latched as (row-(K-1), col-(K-1)).
  - If s_valid is low, the state holds and nothing advances.
- **COMPUTE**
  - s_ready=0 and mac_en=1 for exactly OUT_CH*IN_CH = 96 consecutive cycles.
  - in_ch counts 0..5 as the inner loop and out_ch counts 0..15 as the outer loop.
  - w_addr = out_ch*6 + in_ch; acc_clr = (in_ch==0); acc_last = (in_ch==5).
  - On the 96th cycle (out_ch=15, in_ch=5):
    - If the window just computed is the last one (row IMG_H-K, col IMG_W-K), the next state is DRAIN.
    - Otherwise the next state is FILL.
- **DRAIN**
  - s_ready=0; waits MAC_LAT cycles for the final result.
  - Then returns to FILL with (row,col)=(0,0), ready for the next frame.
- **Result tagging**
  - A MAC_LAT-deep shift register carries {acc_last-issue, out_ch, out_row, out_col, last-of-frame}.
  - out_valid is asserted from the delayed acc_last-issue bit. frame_done is asserted from the delayed last-of-frame bit.
  - Issue sideband signals change only while mac_en=1. When mac_en=0, in_ch_sel, w_addr, acc_clr and acc_last are 0.
- There is no downstream backpressure. The consumer must absorb one out_valid every 6 cycles during COMPUTE.

## Timing
- s_ready is combinational from the state register. The other issue outputs are decoded from registered counters and are valid in the issue cycle.
- Latency from the accepting edge of a window-completing pixel to its first mac_en is 1 cycle.
- Latency from an acc_last issue to out_valid is MAC_LAT cycles.
- Per frame with continuous s_valid: 144 accept cycles + 64 windows × 96 = 6288 cycles, plus MAC_LAT drain cycles.
- 64 windows × 16 channels = 1024 out_valid pulses and exactly 1 frame_done per frame.
- A pixel is never accepted while COMPUTE or DRAIN is active. s_valid held high across a stall must not lose or duplicate a pixel.

## Test plan
1. **Reset values:** hold rst 3 cycles → s_ready=1 and all other outputs 0. Assert rst mid-COMPUTE (window 10, out_ch 7) → next cycle FILL, col=row=0, and no out_valid follows.
2. **First window:** continuous s_valid from cycle 0 (pixel k accepted in cycle k) → pixel 52 (row 4, col 4) accepted in cycle 52. s_ready=0 for cycles 53..148, w_addr 0..95 in order, acc_clr in cycles 53,59,…. First out_valid in cycle 61 with out_ch=0 and (out_row,out_col)=(0,0).
3. **Row wrap:** after window (0,7), the next accepted pixels are (5,0)…(5,3) with no COMPUTE. COMPUTE starts only after (5,4), with window (1,0).
4. **Full frame, continuous:** 144 pixels → 1024 out_valid, with out_ch cycling 0..15 per window and windows in raster order (0,0)…(7,7). frame_done coincides with out_valid for out_ch=15 at (7,7). The cycle after DRAIN: s_ready=1 with counters 0.
5. **Gapped input:** s_valid with a random 30% duty, held high through stalls → same 1024 results, same tags and order as scenario 4. The bench checks that exactly 144 pixels are accepted per frame.
6. **Back-to-back frames:** two frames streamed continuously → 2 frame_done pulses, 2048 out_valid. The second frame's first window is (0,0) and w_addr restarts at 0.

Source files
------------

// File: rtl/conv2_sched.sv
// conv2_sched: sequencing controller for the 5x5x6 -> 16 convolution layer.
// Accepts raster-ordered pixels (all input channels at once), detects when a
// full KxK window is resident, then stalls the input while it issues
// OUT_CH*IN_CH MAC steps. Each accumulation's final result is tagged with its
// output channel and window position after MAC_LAT cycles.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready pixel handshake; pix_we marks an accepted pixel
//   mac_en          MAC issue this cycle
//   in_ch_sel       input channel of the issue
//   w_addr          weight ROM address, out_ch*IN_CH + in_ch
//   acc_clr         first issue of an accumulation
//   acc_last        last issue of an accumulation
//   out_valid       accumulator result final this cycle
//   out_ch/out_row/out_col  tag of the out_valid result
//   frame_done      coincides with the last out_valid of a frame
//   busy            computing or draining
module conv2_sched #(
    parameter int unsigned IMG_W   = 12,
    parameter int unsigned IMG_H   = 12,
    parameter int unsigned K       = 5,
    parameter int unsigned IN_CH   = 6,
    parameter int unsigned OUT_CH  = 16,
    parameter int unsigned MAC_LAT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       pix_we,
    output logic       mac_en,
    output logic [2:0] in_ch_sel,
    output logic [6:0] w_addr,
    output logic       acc_clr,
    output logic       acc_last,
    output logic       out_valid,
    output logic [3:0] out_ch,
    output logic [2:0] out_row,
    output logic [2:0] out_col,
    output logic       frame_done,
    output logic       busy
);

    localparam int unsigned ColW = $clog2(IMG_W);
    localparam int unsigned RowW = $clog2(IMG_H);
    localparam int unsigned DrW  = $clog2(MAC_LAT + 1);

    localparam logic [ColW-1:0] ColLast    = ColW'(IMG_W - 1);
    localparam logic [RowW-1:0] RowLast    = RowW'(IMG_H - 1);
    localparam logic [ColW-1:0] ColK1      = ColW'(K - 1);
    localparam logic [RowW-1:0] RowK1      = RowW'(K - 1);
    localparam logic [2:0]      InChLast   = 3'(IN_CH - 1);
    localparam logic [3:0]      OutChLast  = 4'(OUT_CH - 1);
    localparam logic [2:0]      WinRowLast = 3'(IMG_H - K);
    localparam logic [2:0]      WinColLast = 3'(IMG_W - K);
    localparam logic [DrW-1:0]  DrLast     = DrW'(MAC_LAT - 1);

    typedef enum logic [1:0] {StFill, StCompute, StDrain} state_e;

    typedef struct packed {
        logic       vld;
        logic [3:0] ch;
        logic [2:0] row;
        logic [2:0] col;
        logic       lof;
    } tag_t;

    state_e          state_q, state_d;
    logic [ColW-1:0] col_q, col_d;
    logic [RowW-1:0] row_q, row_d;
    logic [2:0]      win_row_q, win_row_d;
    logic [2:0]      win_col_q, win_col_d;
    logic [2:0]      in_ch_q, in_ch_d;
    logic [3:0]      out_ch_q, out_ch_d;
    logic [6:0]      w_addr_q, w_addr_d;
    logic [DrW-1:0]  drain_q, drain_d;
    tag_t            dl_q [MAC_LAT];
    tag_t            tag_in;
    logic            last_win;

    assign last_win = (win_row_q == WinRowLast) && (win_col_q == WinColLast);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        in_ch_d   = in_ch_q;
        out_ch_d  = out_ch_q;
        w_addr_d  = w_addr_q;
        drain_d   = drain_q;
        unique case (state_q)
            StFill: begin
                if (s_valid) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    // This pixel completes the window whose bottom-right corner it is.
                    if (row_q >= RowK1 && col_q >= ColK1) begin
                        state_d   = StCompute;
                        win_row_d = 3'(row_q - RowK1);
                        win_col_d = 3'(col_q - ColK1);
                        in_ch_d   = '0;
                        out_ch_d  = '0;
                        w_addr_d  = '0;
                    end
                end
            end
            StCompute: begin
                w_addr_d = w_addr_q + 7'd1;
                if (in_ch_q == InChLast) begin
                    in_ch_d = '0;
                    if (out_ch_q == OutChLast) begin
                        out_ch_d = '0;
                        w_addr_d = '0;
                        if (last_win) begin
                            state_d = StDrain;
                            drain_d = '0;
                        end else begin
                            state_d = StFill;
                        end
                    end else begin
                        out_ch_d = out_ch_q + 4'd1;
                    end
                end else begin
                    in_ch_d = in_ch_q + 3'd1;
                end
            end
            StDrain: begin
                if (drain_q == DrLast) begin
                    state_d = StFill;
                    col_d   = '0;
                    row_d   = '0;
                    drain_d = '0;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFill;
            col_q     <= '0;
            row_q     <= '0;
            win_row_q <= '0;
            win_col_q <= '0;
            in_ch_q   <= '0;
            out_ch_q  <= '0;
            w_addr_q  <= '0;
            drain_q   <= '0;
            for (int i = 0; i < int'(MAC_LAT); i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            win_row_q <= win_row_d;
            win_col_q <= win_col_d;
            in_ch_q   <= in_ch_d;
            out_ch_q  <= out_ch_d;
            w_addr_q  <= w_addr_d;
            drain_q   <= drain_d;
            dl_q[0]   <= tag_in;
            for (int i = 1; i < int'(MAC_LAT); i++) begin
                dl_q[i] <= dl_q[i-1];
            end
        end
    end

    always_comb begin
        s_ready   = (state_q == StFill);
        pix_we    = s_valid && s_ready;
        mac_en    = (state_q == StCompute);
        busy      = (state_q != StFill);
        in_ch_sel = mac_en ? in_ch_q : 3'd0;
        w_addr    = mac_en ? w_addr_q : 7'd0;
        acc_clr   = mac_en && (in_ch_q == 3'd0);
        acc_last  = mac_en && (in_ch_q == InChLast);
        // Tag fields are zeroed on non-final issues so idle delay-line slots stay clean.
        tag_in    = '0;
        if (acc_last) begin
            tag_in.vld = 1'b1;
            tag_in.ch  = out_ch_q;
            tag_in.row = win_row_q;
            tag_in.col = win_col_q;
            tag_in.lof = last_win && (out_ch_q == OutChLast);
        end
        out_valid  = dl_q[MAC_LAT-1].vld;
        out_ch     = dl_q[MAC_LAT-1].ch;
        out_row    = dl_q[MAC_LAT-1].row;
        out_col    = dl_q[MAC_LAT-1].col;
        frame_done = dl_q[MAC_LAT-1].vld && dl_q[MAC_LAT-1].lof;
    end

endmodule
